// File: rtl/mem_interface.sv
// Memory access controller for the Mini SRC datapath: holds MAR/MDR and sequences
// programmable wait states, a single ram access, and a one-cycle done pulse.
module mem_interface #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_bus_in,
  input  logic              i_mar_in,
  input  logic              i_mdr_in,
  input  logic              i_rd_req,
  input  logic              i_wr_req,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_mar_out,
  output logic [DATA_W-1:0] o_mdr_out,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_w_data,
  output logic              o_ram_wr_en,
  input  logic [DATA_W-1:0] i_ram_r_data,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LP_WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_wait_cnt;
  logic                r_op_wr;
  logic [ADDR_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_mdr;
  logic                w_req;

  // Handshake: requests and register loads are accepted only while busy is low;
  // each accepted request yields exactly one done pulse and nothing is queued.
  assign w_req = i_rd_req | i_wr_req;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (WAIT_CYCLES > 0) w_next = S_WAIT;
          else                 w_next = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == LP_WAIT_LAST) w_next = S_ACCESS;
      end
      S_ACCESS: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_op_wr    <= 1'b0;
      r_mar      <= '0;
      r_mdr      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_wait_cnt <= 4'd0;
          if (i_mar_in) r_mar <= i_bus_in[ADDR_W-1:0];
          if (i_mdr_in) r_mdr <= i_bus_in;
          // Read wins a collision; the write request is simply dropped.
          if (w_req) r_op_wr <= ~i_rd_req;
        end
        S_WAIT: r_wait_cnt <= r_wait_cnt + 4'd1;
        S_ACCESS: begin
          if (!r_op_wr) r_mdr <= i_ram_r_data;
        end
        default: ;
      endcase
    end
  end

  // Write enable is decoded from state alone, so it cannot glitch on inputs.
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_ram_wr_en  = (r_state == S_ACCESS) && r_op_wr;
  assign o_mar_out    = r_mar;
  assign o_mdr_out    = r_mdr;
  assign o_ram_addr   = r_mar;
  assign o_ram_w_data = r_mdr;
  assign o_state      = r_state;

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: a table of per-cycle vectors on a
// WAIT_CYCLES=1 instance plus directed sequences, including a WAIT_CYCLES=0 instance.
module tb_mem_interface;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WAIT_CYCLES=1
  logic        reset0, mar_in0, mdr_in0, rd0, wr0;
  logic [31:0] bus0;
  logic        busy0, done0, wr_en0;
  logic [8:0]  mar_out0, addr0;
  logic [31:0] mdr_out0, w_data0, r_data0;
  logic [1:0]  state0;

  // Instance 1: WAIT_CYCLES=0
  logic        reset1, mar_in1, mdr_in1, rd1, wr1;
  logic [31:0] bus1;
  logic        busy1, done1, wr_en1;
  logic [8:0]  mar_out1, addr1;
  logic [31:0] mdr_out1, w_data1, r_data1;
  logic [1:0]  state1;

  logic        tb_init;
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];

  mem_interface #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) dut0 (
    .i_clk(clk), .i_reset(reset0), .i_bus_in(bus0), .i_mar_in(mar_in0), .i_mdr_in(mdr_in0),
    .i_rd_req(rd0), .i_wr_req(wr0), .o_busy(busy0), .o_done(done0), .o_mar_out(mar_out0),
    .o_mdr_out(mdr_out0), .o_ram_addr(addr0), .o_ram_w_data(w_data0), .o_ram_wr_en(wr_en0),
    .i_ram_r_data(r_data0), .o_state(state0)
  );

  mem_interface #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut1 (
    .i_clk(clk), .i_reset(reset1), .i_bus_in(bus1), .i_mar_in(mar_in1), .i_mdr_in(mdr_in1),
    .i_rd_req(rd1), .i_wr_req(wr1), .o_busy(busy1), .o_done(done1), .o_mar_out(mar_out1),
    .o_mdr_out(mdr_out1), .o_ram_addr(addr1), .o_ram_w_data(w_data1), .o_ram_wr_en(wr_en1),
    .i_ram_r_data(r_data1), .o_state(state1)
  );

  // Ram models: combinational read, write on the rising edge.
  assign r_data0 = mem0[addr0];
  assign r_data1 = mem1[addr1];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 512; i++) mem0[i] <= 32'hC000_0000 | i;
    end else if (wr_en0) begin
      mem0[addr0] <= w_data0;
    end
  end

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 512; i++) mem1[i] <= 32'hC000_0000 | i;
    end else if (wr_en1) begin
      mem1[addr1] <= w_data1;
    end
  end

  // Scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        mar_in, mdr_in, rd, wr;
    logic [31:0] bus;
    logic        busy, done, wr_en;
    logic [8:0]  mar;
    logic [31:0] mdr;
  } vec_t;

  vec_t vt [24];

  function automatic vec_t mk(input logic ma, input logic md, input logic r, input logic w,
                              input logic [31:0] b, input logic bz, input logic dn,
                              input logic we, input logic [8:0] m, input logic [31:0] d);
    vec_t v;
    v.mar_in = ma; v.mdr_in = md; v.rd = r; v.wr = w; v.bus = b;
    v.busy = bz; v.done = dn; v.wr_en = we; v.mar = m; v.mdr = d;
    return v;
  endfunction

  initial begin
    // Expected values are the outputs right after the edge each vector is applied to.
    //          ma md rd wr bus            busy done wren mar     mdr
    vt[0]  = mk(1, 0, 0, 0, 32'h0000_01A5, 0, 0, 0, 9'h1A5, 32'h0000_0000);
    vt[1]  = mk(0, 1, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 9'h1A5, 32'hDEAD_BEEF);
    vt[2]  = mk(0, 0, 0, 1, 32'h0,         1, 0, 0, 9'h1A5, 32'hDEAD_BEEF);
    vt[3]  = mk(0, 0, 0, 0, 32'h0,         1, 0, 1, 9'h1A5, 32'hDEAD_BEEF);
    vt[4]  = mk(0, 0, 0, 0, 32'h0,         1, 1, 0, 9'h1A5, 32'hDEAD_BEEF);
    vt[5]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 9'h1A5, 32'hDEAD_BEEF);
    vt[6]  = mk(0, 1, 0, 0, 32'h0,         0, 0, 0, 9'h1A5, 32'h0000_0000);
    vt[7]  = mk(0, 0, 1, 0, 32'h0,         1, 0, 0, 9'h1A5, 32'h0000_0000);
    vt[8]  = mk(0, 0, 0, 0, 32'h0,         1, 0, 0, 9'h1A5, 32'h0000_0000);
    vt[9]  = mk(0, 0, 0, 0, 32'h0,         1, 1, 0, 9'h1A5, 32'hDEAD_BEEF);
    vt[10] = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 9'h1A5, 32'hDEAD_BEEF);
    vt[11] = mk(1, 0, 0, 0, 32'hFFFF_F200, 0, 0, 0, 9'h000, 32'hDEAD_BEEF);
    vt[12] = mk(0, 1, 0, 0, 32'h1234_5678, 0, 0, 0, 9'h000, 32'h1234_5678);
    vt[13] = mk(0, 0, 0, 1, 32'h0,         1, 0, 0, 9'h000, 32'h1234_5678);
    vt[14] = mk(1, 1, 0, 1, 32'h0AAA_AAAA, 1, 0, 1, 9'h000, 32'h1234_5678);
    vt[15] = mk(1, 1, 0, 1, 32'h0AAA_AAAA, 1, 1, 0, 9'h000, 32'h1234_5678);
    vt[16] = mk(0, 0, 1, 1, 32'h0,         0, 0, 0, 9'h000, 32'h1234_5678);
    vt[17] = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 9'h000, 32'h1234_5678);
    vt[18] = mk(1, 0, 0, 0, 32'h0000_01A5, 0, 0, 0, 9'h1A5, 32'h1234_5678);
    vt[19] = mk(0, 1, 0, 0, 32'h5555_5555, 0, 0, 0, 9'h1A5, 32'h5555_5555);
    vt[20] = mk(0, 0, 1, 1, 32'h0,         1, 0, 0, 9'h1A5, 32'h5555_5555);
    vt[21] = mk(0, 0, 0, 0, 32'h0,         1, 0, 0, 9'h1A5, 32'h5555_5555);
    vt[22] = mk(0, 0, 0, 0, 32'h0,         1, 1, 0, 9'h1A5, 32'hDEAD_BEEF);
    vt[23] = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 9'h1A5, 32'hDEAD_BEEF);

    // Reset block
    tb_init = 1'b1;
    reset0 = 1'b1; mar_in0 = 0; mdr_in0 = 0; rd0 = 0; wr0 = 0; bus0 = 32'h0;
    reset1 = 1'b1; mar_in1 = 0; mdr_in1 = 0; rd1 = 0; wr1 = 0; bus1 = 32'h0;
    tick();
    tick();
    check("rst_busy",  busy0,    0);
    check("rst_done",  done0,    0);
    check("rst_mar",   mar_out0, 0);
    check("rst_mdr",   mdr_out0, 0);
    check("rst_wr_en", wr_en0,   0);
    check("rst1_busy", busy1,    0);
    check("rst1_mdr",  mdr_out1, 0);
    reset0 = 1'b0;
    reset1 = 1'b0;
    tb_init = 1'b0;

    // Table-driven vectors on instance 0
    for (int i = 0; i < 24; i++) begin
      mar_in0 = vt[i].mar_in; mdr_in0 = vt[i].mdr_in;
      rd0 = vt[i].rd; wr0 = vt[i].wr; bus0 = vt[i].bus;
      tick();
      check($sformatf("v%0d_busy", i),   busy0,    vt[i].busy);
      check($sformatf("v%0d_done", i),   done0,    vt[i].done);
      check($sformatf("v%0d_wr_en", i),  wr_en0,   vt[i].wr_en);
      check($sformatf("v%0d_mar", i),    mar_out0, vt[i].mar);
      check($sformatf("v%0d_mdr", i),    mdr_out0, vt[i].mdr);
      check($sformatf("v%0d_addr", i),   addr0,    vt[i].mar);
      check($sformatf("v%0d_w_data", i), w_data0,  vt[i].mdr);
    end
    mar_in0 = 0; mdr_in0 = 0; rd0 = 0; wr0 = 0; bus0 = 32'h0;
    check("mem_1a5_kept", mem0[9'h1A5], 32'hDEAD_BEEF);
    check("mem_000_wr",   mem0[9'h000], 32'h1234_5678);
    check("mem_0aa_untouched", mem0[9'h0AA], 32'hC000_00AA);

    // WAIT_CYCLES=0: read mem[3]
    mar_in1 = 1; bus1 = 32'h0000_0003;
    tick();
    check("z_mar", mar_out1, 9'h003);
    mar_in1 = 0; rd1 = 1;
    tick();
    rd1 = 0;
    check("z_e0_busy",  busy1,  1);
    check("z_e0_state", state1, 2'd2);
    check("z_e0_done",  done1,  0);
    tick();
    check("z_e1_done",  done1,    1);
    check("z_e1_mdr",   mdr_out1, 32'hC000_0003);
    check("z_e1_wr_en", wr_en1,   0);
    tick();
    check("z_e2_busy",  busy1,  0);
    check("z_e2_done",  done1,  0);

    // Reset while a write sits in WAIT
    mar_in0 = 1; bus0 = 32'h0000_0010;
    tick();
    mar_in0 = 0; mdr_in0 = 1; bus0 = 32'hBAD0_BAD0;
    tick();
    check("r_mdr_load", mdr_out0, 32'hBAD0_BAD0);
    mdr_in0 = 0; wr0 = 1;
    tick();
    wr0 = 0;
    check("r_wait_state", state0, 2'd1);
    check("r_wait_wr_en", wr_en0, 0);
    reset0 = 1'b1;
    tick();
    reset0 = 1'b0;
    check("r_busy",  busy0,    0);
    check("r_mar",   mar_out0, 0);
    check("r_mdr",   mdr_out0, 0);
    check("r_wr_en", wr_en0,   0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("r_post%0d_done", k),  done0,  0);
      check($sformatf("r_post%0d_wr_en", k), wr_en0, 0);
      check($sformatf("r_post%0d_busy", k),  busy0,  0);
    end
    check("r_mem_010", mem0[9'h010], 32'hC000_0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
